// File: rtl/if_stage_if.sv
// Instruction RAM bus between the fetch stage (master) and the RAM (slave).
// The RAM answers rom_addr combinationally on rom_data.
interface if_stage_if;
   logic [31:0] rom_addr;
   logic        rom_ce;
   logic [31:0] rom_data;

   modport master (
      output rom_addr,
      output rom_ce,
      input  rom_data
   );

   modport slave (
      input  rom_addr,
      input  rom_ce,
      output rom_data
   );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, RAM enable and the IF/ID pipeline register.
// Update priority each edge: reset > enable warm-up > flush > stall > branch > sequential.
module if_stage (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_flag,
   input  logic [31:0]       branch_target,
   input  logic              flush,
   input  logic [31:0]       flush_target,
   if_stage_if.master        rom,
   output logic [31:0]       id_pc,
   output logic [31:0]       id_inst,
   output logic              id_valid,
   output logic [31:0]       fetch_count
);

   localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

   logic [31:0] pc_q, pc_d;
   logic        rom_ce_q, rom_ce_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] fetch_count_q, fetch_count_d;

   always_comb begin
      pc_d          = pc_q;
      rom_ce_d      = rom_ce_q;
      id_pc_d       = id_pc_q;
      id_inst_d     = id_inst_q;
      id_valid_d    = id_valid_q;
      fetch_count_d = fetch_count_q;

      if (!rom_ce_q) begin
         // First edge out of reset only enables the RAM; nothing is fetched yet.
         rom_ce_d   = 1'b1;
         pc_d       = 32'h0;
         id_pc_d    = 32'h0;
         id_inst_d  = 32'h0;
         id_valid_d = 1'b0;
      end else if (flush) begin
         pc_d       = flush_target & ALIGN_MASK;
         id_pc_d    = 32'h0;
         id_inst_d  = 32'h0;
         id_valid_d = 1'b0;
      end else if (!stall) begin
         // The word at the current PC is delivered whether or not a branch redirects the PC.
         id_pc_d       = pc_q;
         id_inst_d     = rom.rom_data;
         id_valid_d    = 1'b1;
         fetch_count_d = fetch_count_q + 32'd1;
         pc_d          = branch_flag ? (branch_target & ALIGN_MASK) : (pc_q + 32'd4);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= 32'h0;
         rom_ce_q      <= 1'b0;
         id_pc_q       <= 32'h0;
         id_inst_q     <= 32'h0;
         id_valid_q    <= 1'b0;
         fetch_count_q <= 32'h0;
      end else begin
         pc_q          <= pc_d;
         rom_ce_q      <= rom_ce_d;
         id_pc_q       <= id_pc_d;
         id_inst_q     <= id_inst_d;
         id_valid_q    <= id_valid_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign rom.rom_addr = pc_q;
   assign rom.rom_ce   = rom_ce_q;
   assign id_pc        = id_pc_q;
   assign id_inst      = id_inst_q;
   assign id_valid     = id_valid_q;
   assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal checks, then random traffic
// compared every cycle against a behavioural fetch model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        flush = 1'b0;
   logic [31:0] flush_target = 32'h0;
   logic [31:0] id_pc, id_inst, fetch_count;
   logic        id_valid;

   logic [31:0] mem [256];

   int tests = 0;
   int fails = 0;
   bit check_en = 1'b0;

   // Behavioural model state
   logic [31:0] m_pc = 32'h0;
   logic        m_ce = 1'b0;
   logic [31:0] m_id_pc = 32'h0;
   logic [31:0] m_id_inst = 32'h0;
   logic        m_id_valid = 1'b0;
   logic [31:0] m_count = 32'h0;

   if_stage_if rom_bus ();
   assign rom_bus.rom_data = mem[rom_bus.rom_addr[9:2]];

   if_stage dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .flush         (flush),
      .flush_target  (flush_target),
      .rom           (rom_bus.master),
      .id_pc         (id_pc),
      .id_inst       (id_inst),
      .id_valid      (id_valid),
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   // Model: what the stage must hold after each edge, from the rule list.
   always @(posedge clk) begin
      if (rst) begin
         m_pc = 0; m_ce = 0; m_id_pc = 0; m_id_inst = 0; m_id_valid = 0; m_count = 0;
      end else if (!m_ce) begin
         m_ce = 1;
      end else if (flush) begin
         m_pc = {flush_target[31:2], 2'b00};
         m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
      end else if (!stall) begin
         m_id_pc    = m_pc;
         m_id_inst  = mem[m_pc[9:2]];
         m_id_valid = 1;
         m_count    = m_count + 1;
         if (branch_flag) m_pc = {branch_target[31:2], 2'b00};
         else             m_pc = m_pc + 4;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("rom_addr", rom_bus.rom_addr, m_pc);
         chk("rom_ce", {31'b0, rom_bus.rom_ce}, {31'b0, m_ce});
         chk("id_pc", id_pc, m_id_pc);
         chk("id_inst", id_inst, m_id_inst);
         chk("id_valid", {31'b0, id_valid}, {31'b0, m_id_valid});
         chk("fetch_count", fetch_count, m_count);
      end
   end

   task automatic cyc(input logic s, input logic b, input logic [31:0] bt,
                      input logic f, input logic [31:0] ft);
      stall = s; branch_flag = b; branch_target = bt; flush = f; flush_target = ft;
      @(posedge clk);
      #1;
      $display("[TB] cyc rst=%0b stall=%0b br=%0b bt=%08h fl=%0b ft=%08h -> pc=%08h id_pc=%08h v=%0b cnt=%0d",
               rst, s, b, bt, f, ft, rom_bus.rom_addr, id_pc, id_valid, fetch_count);
   endtask

   task automatic seq(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 0, 0, 0);
         check_en = 1'b1;
      end
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;

      // Reset release and sequential fetch
      do_reset(10);
      chk("reset_rom_ce", {31'b0, rom_bus.rom_ce}, 32'h0);
      chk("reset_count", fetch_count, 32'h0);
      seq(1);
      chk("ce_after_release", {31'b0, rom_bus.rom_ce}, 32'h1);
      chk("pc_after_release", rom_bus.rom_addr, 32'h0);
      seq(1);
      chk("first_inst", id_inst, mem[0]);
      seq(6);
      chk("count_7", fetch_count, 32'd7);
      chk("id_pc_7th", id_pc, 32'h18);
      chk("inst_7th", id_inst, mem[6]);

      // Stall at PC=0x8
      do_reset(2);
      seq(3);
      chk("pre_stall_pc", rom_bus.rom_addr, 32'h8);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 32'h100, 0, 0);
         chk("stall_pc", rom_bus.rom_addr, 32'h8);
         chk("stall_id_pc", id_pc, 32'h4);
         chk("stall_count", fetch_count, 32'd2);
      end
      seq(1);
      chk("stall_release_id_pc", id_pc, 32'h8);

      // Branch with delay slot from PC=0xC
      cyc(0, 1, 32'h40, 0, 0);
      chk("delay_slot_id_pc", id_pc, 32'hC);
      chk("delay_slot_valid", {31'b0, id_valid}, 32'h1);
      chk("branch_pc", rom_bus.rom_addr, 32'h40);
      seq(1);
      chk("branch_target_id_pc", id_pc, 32'h40);

      // Flush beats stall and branch
      cyc(1, 1, 32'h80, 1, 32'h183);
      chk("flush_pc", rom_bus.rom_addr, 32'h180);
      chk("flush_valid", {31'b0, id_valid}, 32'h0);
      chk("flush_inst", id_inst, 32'h0);
      chk("flush_count", fetch_count, 32'd5);

      // Wrap through 0xFFFFFFFC using a misaligned target
      cyc(0, 1, 32'hFFFF_FFFE, 0, 0);
      chk("wrap_pre_pc", rom_bus.rom_addr, 32'hFFFF_FFFC);
      seq(1);
      chk("wrap_pc", rom_bus.rom_addr, 32'h0);
      chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

      // Reset during a stall at PC=0x20
      do_reset(1);
      seq(9);
      chk("pre_rst_pc", rom_bus.rom_addr, 32'h20);
      rst = 1'b1;
      cyc(1, 0, 0, 0, 0);
      rst = 1'b0;
      chk("midrst_pc", rom_bus.rom_addr, 32'h0);
      chk("midrst_ce", {31'b0, rom_bus.rom_ce}, 32'h0);
      chk("midrst_count", fetch_count, 32'h0);
      chk("midrst_valid", {31'b0, id_valid}, 32'h0);
      seq(2);
      chk("resume_id_pc", id_pc, 32'h0);
      chk("resume_inst", id_inst, mem[0]);

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         rst = ($urandom_range(0, 63) == 0);
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom,
             $urandom_range(0, 9) == 0, $urandom);
      end
      rst = 1'b0;
      seq(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL expose these ports, one per line: name  direction  width  meaning.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stall  input  1  hazard stall from decode; holds PC and the IF/ID register.
REQ-005 branch_flag  input  1  taken branch/jump resolved in decode this cycle.
REQ-006 branch_target  input  32  byte address of the branch destination.
REQ-007 flush  input  1  exception/redirect request; cancels the instruction being fetched.
REQ-008 flush_target  input  32  byte address to restart fetch from on flush.
REQ-009 rom_data  input  32  instruction word from instruction RAM, combinational read of rom_addr.
REQ-010 rom_addr  output  32  byte fetch address; always equals the current PC.
REQ-011 rom_ce  output  1  RAM chip enable; 1 when fetch is active.
REQ-012 id_pc  output  32  registered PC of the instruction handed to decode.
REQ-013 id_inst  output  32  registered instruction handed to decode; 0x00000000 (nop) when invalid.
REQ-014 id_valid  output  1  registered; 1 when id_inst is a real fetched instruction.
REQ-015 fetch_count  output  32  registered count of instructions delivered to decode.

Function
REQ-016 State SHALL be the PC register, rom_ce register, IF/ID register (id_pc, id_inst, id_valid) and fetch_count.
REQ-017 rom_ce SHALL be 0 while rst=1 and go to 1 on the first rising edge with rst=0, then stay 1.
REQ-018 While rom_ce=0, PC SHALL hold 0 and the IF/ID register SHALL hold nop/invalid.
REQ-019 Update priority each edge with rom_ce=1: flush > stall > branch_flag > sequential.
REQ-020 flush=1: PC <= {flush_target[31:2],2'b00}; id_inst <= 0, id_valid <= 0, id_pc <= 0; fetch_count unchanged.
REQ-021 stall=1 (no flush): PC, IF/ID and fetch_count SHALL hold; branch_flag is ignored that cycle and decode re-asserts it.
REQ-022 branch_flag=1 (no flush/stall): PC <= {branch_target[31:2],2'b00}; the instruction at the current PC (delay slot) SHALL still be loaded into IF/ID with id_valid=1.
REQ-023 Sequential (no flush/stall/branch): id_pc <= PC, id_inst <= rom_data, id_valid <= 1, PC <= PC+4.
REQ-024 Fetch latency: instruction at address A SHALL appear on id_inst exactly one edge after PC=A with no stall.
REQ-025 PC bits [1:0] SHALL always be 0; misaligned targets are silently aligned down.
REQ-026 PC SHALL wrap modulo 2^32: 0xFFFFFFFC + 4 -> 0x00000000.
REQ-027 fetch_count SHALL increment by 1 on every edge that loads IF/ID with id_valid=1, wrapping 0xFFFFFFFF -> 0.
REQ-028 rom_addr SHALL be driven combinationally from PC; no other combinational path input-to-output.

Reset
REQ-029 rst=1 at an edge SHALL set PC=0, rom_ce=0, id_pc=0, id_inst=0, id_valid=0, fetch_count=0, overriding all other inputs.
REQ-030 rst asserted mid-stall, mid-branch or mid-flush SHALL discard the pending operation entirely; fetch restarts at 0x00000000.

Verification
REQ-031 Reset release: rst=1 for 10 cycles then 0, RAM words 0..6 loaded -> rom_ce=1 after first edge; id_pc sequence 0x0,0x4,0x8,... one per cycle, id_inst = RAM[0],RAM[1],...; fetch_count=7 after 7 deliveries.
REQ-032 Stall: stall=1 for 3 cycles while PC=0x8 -> PC stays 0x8, id_pc stays 0x4, fetch_count frozen; release -> id_pc=0x8 next edge.
REQ-033 Branch with delay slot: branch_flag=1, branch_target=0x40 while PC=0xC -> next edge id_pc=0xC (valid), PC=0x40; following edge id_pc=0x40.
REQ-034 Flush vs stall/branch: flush=1, stall=1, branch_flag=1, flush_target=0x183 -> PC=0x180, id_valid=0, id_inst=0, fetch_count unchanged.
REQ-035 Wrap: force PC to 0xFFFFFFFC via branch_target -> after one sequential edge PC=0x00000000, id_pc=0xFFFFFFFC.
REQ-036 Reset mid-operation: rst=1 during stall with PC=0x20 -> PC=0, all outputs at reset values next edge, fetch resumes at 0x0 after release.
